window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Forms 3×3 convolution windows from three parallel 8-bit row streams and sits directly downstream of the CCM row-reuse buffer. The two reused rows from that buffer enter as the top and middle rows. The freshly fetched image row enters as the bottom row. The block keeps a 3-column shift window per row and emits one packed 72-bit window per valid output position, tagged with its output coordinates. It also sequences one frame: it latches the frame dimensions, counts row-triplets, and signals completion.

## Interface
- DW, 8, pixel width in bits.
- CW, 9, width of the dimension and coordinate fields.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  frame enable. The rising edge starts a frame. Low aborts the frame and returns the block to idle.
- col  in  CW  image width in pixels. Latched on the cycle en is first seen high.
- row  in  CW  image height in pixels. Latched with col.
- in_valid  in  1  px0/px1/px2 hold one column of the current row-triplet.
- px0  in  DW  top-row pixel (reuse buffer output 1).
- px1  in  DW  middle-row pixel (reuse buffer output 2).
- px2  in  DW  bottom-row pixel (new row).
- win_valid  out  1  win, win_col and win_row are valid this cycle.
- win  out  9*DW  window. Bits [71:64] hold w00 (top-left), then w01, w02, w10, w11, w12, w20, w21, with w22 (bottom-right) in bits [7:0]. The second digit is the column, where 0 is the oldest/leftmost sample.
- win_col  out  CW  output column index, 0..col-3.
- win_row  out  CW  output row index, 0..row-3.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse at the end of the frame.

## Operation
- State IDLE, entered from reset or whenever en=0:
  - Counters are cleared and in_valid is ignored.
  - When en=1, latch col and row into col_q and row_q.
  - If col<3 or row<3, go to DONE and pulse frame_done. No windows are produced.
  - Otherwise go to RUN.
- State RUN:
  - Each in_valid updates the shift window for r=0..2: s[r][0] <= s[r][1], s[r][1] <= s[r][2], s[r][2] <= px_r.
  - in_col counts 0..col_q-1. At col_q-1 it wraps to 0 and in_row increments.
  - A window is produced for every accepted pixel with in_col >= 2. Its output column is in_col-2 and its output row is in_row.
  - The accept with in_col == col_q-1 and in_row == row_q-3 is the last one of the frame: go to DONE and pulse frame_done together with that final win_valid.
- State DONE: in_valid is ignored and outputs hold. Leave to IDLE when en=0.
- en=0 in any state goes to IDLE on the next edge:
  - win_valid, busy and frame_done are forced to 0.
  - A partial window is discarded.
- The shift registers are not cleared at a row wrap. The first two columns of each row-triplet produce no output, so no stale data can escape.
- Arithmetic: compare using col_q-1 and row_q-3 computed at CW bits. These never underflow because col and row are validated to be >= 3.
- Total windows per frame: (row_q-2)*(col_q-2).
- in_valid gaps of any length are legal. The window advances only on accepts.

## Timing
- Reset values: all outputs are 0, state is IDLE, and all shift registers are 0.
- Latency: the window is registered, so win_valid, win, win_col and win_row appear exactly one cycle after the accepting in_valid edge.
- Back-to-back accepts within a row give one window per cycle.
- At a row wrap there is a 2-cycle output bubble even with continuous in_valid.
- The transition from IDLE to RUN takes 1 cycle after en is sampled high. in_valid in that same cycle is ignored.
- frame_done is coincident with the last win_valid and lasts exactly 1 cycle. busy falls on the same edge.
- There is no backpressure. The consumer must accept every win_valid.
- If in_valid and en=0 are asserted in the same cycle, the abort wins and the pixel is dropped.

## Test plan
- Basic frame, col=5, row=4, continuous in_valid, with px0=c, px1=16+c, px2=32+c:
  - Exactly 6 windows are produced.
  - The first has win = 00,01,02,10,11,12,20,21,22 (hex bytes) with win_col=0, win_row=0.
  - frame_done coincides with the window at win_col=2, win_row=1.
- Row wrap: in the same frame, the window at win_row=1, win_col=0 contains only the second triplet's columns 0..2.
  - win_valid is low for exactly 2 cycles between win_col=2 of row 0 and win_col=0 of row 1.
- Gapped input: col=4, row=3, in_valid on alternate cycles.
  - 2 windows are produced, each exactly 1 cycle after its accept, with correct contents.
- Degenerate size: col=2, row=10, then en rises.
  - frame_done pulses once, no win_valid occurs, and busy never asserts.
- Abort: drop en after 3 windows of a col=6, row=6 frame.
  - Outputs go to 0 next cycle.
  - Re-raising en restarts the frame with win_col=0, win_row=0.
- Asynchronous reset mid-RUN: all outputs are 0 immediately, and after release the state is IDLE.

Source files
------------

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator for three parallel row streams.
// Sequences one frame: latches its dimensions, counts row-triplets, and flags completion.
module window_3x3_gen #(
    parameter int DW = 8,
    parameter int CW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CW-1:0]   col,
    input  logic [CW-1:0]   row,
    input  logic            in_valid,
    input  logic [DW-1:0]   px0,
    input  logic [DW-1:0]   px1,
    input  logic [DW-1:0]   px2,
    output logic            win_valid,
    output logic [9*DW-1:0] win,
    output logic [CW-1:0]   win_col,
    output logic [CW-1:0]   win_row,
    output logic            busy,
    output logic            frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_col_q;
    logic [CW-1:0] r_row_q;
    logic [CW-1:0] r_in_col;
    logic [CW-1:0] r_in_row;
    logic [DW-1:0] r_s [3][3];

    logic [CW-1:0] w_col_last;
    logic [CW-1:0] w_row_last;
    logic          w_bad_size;
    logic          w_accept;
    logic          w_eol;
    logic          w_last;

    assign w_col_last = r_col_q - CW'(1);
    assign w_row_last = r_row_q - CW'(3);
    assign w_bad_size = (col < CW'(3)) || (row < CW'(3));
    assign w_accept   = (r_state == S_RUN) && en && in_valid;
    assign w_eol      = (r_in_col == w_col_last);
    assign w_last     = w_accept && w_eol && (r_in_row == w_row_last);

    assign busy = (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = w_bad_size ? S_DONE : S_RUN;
                S_RUN:   if (w_last) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_q    <= '0;
            r_row_q    <= '0;
            r_in_col   <= '0;
            r_in_row   <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_s[r][c] <= '0;
                end
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (!en) begin
                // Abort: counter reset discards any partial window, outputs read as zero.
                r_in_col <= '0;
                r_in_row <= '0;
                win      <= '0;
                win_col  <= '0;
                win_row  <= '0;
            end else if (r_state == S_IDLE) begin
                r_col_q  <= col;
                r_row_q  <= row;
                r_in_col <= '0;
                r_in_row <= '0;
                if (w_bad_size) begin
                    frame_done <= 1'b1;
                end
            end else if (w_accept) begin
                r_s[0][0] <= r_s[0][1];
                r_s[0][1] <= r_s[0][2];
                r_s[0][2] <= px0;
                r_s[1][0] <= r_s[1][1];
                r_s[1][1] <= r_s[1][2];
                r_s[1][2] <= px1;
                r_s[2][0] <= r_s[2][1];
                r_s[2][1] <= r_s[2][2];
                r_s[2][2] <= px2;

                if (w_eol) begin
                    r_in_col <= '0;
                    r_in_row <= r_in_row + CW'(1);
                end else begin
                    r_in_col <= r_in_col + CW'(1);
                end

                // Window is built from the post-shift view, so the new pixel lands in column 2.
                if (r_in_col >= CW'(2)) begin
                    win_valid <= 1'b1;
                    win       <= {r_s[0][1], r_s[0][2], px0,
                                  r_s[1][1], r_s[1][2], px1,
                                  r_s[2][1], r_s[2][2], px2};
                    win_col   <= r_in_col - CW'(2);
                    win_row   <= r_in_row;
                end

                if (w_last) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed self-checking bench for window_3x3_gen.
// Pixel pattern: value = 16*row_in_triplet + column + 64*triplet.
module tb_window_3x3_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [8:0]  col;
    logic [8:0]  row;
    logic        in_valid;
    logic [7:0]  px0;
    logic [7:0]  px1;
    logic [7:0]  px2;
    logic        win_valid;
    logic [71:0] win;
    logic [8:0]  win_col;
    logic [8:0]  win_row;
    logic        busy;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int nwin;

    window_3x3_gen #(.DW(8), .CW(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .col        (col),
        .row        (row),
        .in_valid   (in_valid),
        .px0        (px0),
        .px1        (px1),
        .px2        (px2),
        .win_valid  (win_valid),
        .win        (win),
        .win_col    (win_col),
        .win_row    (win_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pv(input int r, input int c, input int t);
        return 8'(16 * r + c + 64 * t);
    endfunction

    function automatic logic [71:0] ew(input int c, input int t);
        return {pv(0, c-2, t), pv(0, c-1, t), pv(0, c, t),
                pv(1, c-2, t), pv(1, c-1, t), pv(1, c, t),
                pv(2, c-2, t), pv(2, c-1, t), pv(2, c, t)};
    endfunction

    task automatic drive(input int c, input int t);
        in_valid = 1'b1;
        px0 = pv(0, c, t);
        px1 = pv(1, c, t);
        px2 = pv(2, c, t);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, win_valid, 0);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_col"}, win_col, 0);
        chk({tag, "_row"}, win_row, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; col = '0; row = '0;
        in_valid = 1'b0; px0 = '0; px1 = '0; px2 = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Basic frame 5x4, continuous input
        col = 9'd5; row = 9'd4; en = 1'b1;
        step();
        chk("bf_busy_start", busy, 1);
        chk("bf_valid_start", win_valid, 0);
        nwin = 0;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 5; c++) begin
                drive(c, t);
                step();
                if (win_valid) nwin++;
                chk("bf_valid", win_valid, (c >= 2) ? 1 : 0);
                chk("bf_done", frame_done, (t == 1 && c == 4) ? 1 : 0);
                chk("bf_busy", busy, (t == 1 && c == 4) ? 0 : 1);
                if (c >= 2) begin
                    chk("bf_win", win, ew(c, t));
                    chk("bf_col", win_col, c - 2);
                    chk("bf_row", win_row, t);
                end
                if (t == 0 && c == 2) chk("bf_first", win, 72'h00_01_02_10_11_12_20_21_22);
                if (t == 1 && c == 2) chk("bf_wrap", win, 72'h40_41_42_50_51_52_60_61_62);
                if (t == 1 && c == 4) chk("bf_last", win, 72'h42_43_44_52_53_54_62_63_64);
            end
        end
        chk("bf_count", nwin, 6);
        drive(7, 3);
        step();
        chk("done_valid", win_valid, 0);
        chk("done_pulse", frame_done, 0);
        chk("done_busy", busy, 0);
        chk("done_hold", win, 72'h42_43_44_52_53_54_62_63_64);
        en = 1'b0; in_valid = 1'b0;
        step();
        chk_zero("bf_exit");

        // Gapped frame 4x3, alternate-cycle input
        col = 9'd4; row = 9'd3; en = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            drive(c, 0);
            step();
            chk("gap_valid", win_valid, (c >= 2) ? 1 : 0);
            chk("gap_done", frame_done, (c == 3) ? 1 : 0);
            if (c == 2) chk("gap_w0", win, 72'h00_01_02_10_11_12_20_21_22);
            if (c == 3) chk("gap_w1", win, 72'h01_02_03_11_12_13_21_22_23);
            if (c >= 2) chk("gap_col", win_col, c - 2);
            in_valid = 1'b0;
            step();
            chk("gap_bubble", win_valid, 0);
            chk("gap_done_low", frame_done, 0);
        end
        en = 1'b0;
        step();

        // Degenerate width
        col = 9'd2; row = 9'd10; en = 1'b1;
        step();
        chk("deg_done", frame_done, 1);
        chk("deg_busy", busy, 0);
        chk("deg_valid", win_valid, 0);
        for (int i = 0; i < 3; i++) begin
            drive(i, 0);
            step();
            chk("deg_done_once", frame_done, 0);
            chk("deg_busy_low", busy, 0);
            chk("deg_no_win", win_valid, 0);
        end
        en = 1'b0; in_valid = 1'b0;
        step();

        // Abort after 3 windows of a 6x6 frame; pixel in the abort cycle is dropped
        col = 9'd6; row = 9'd6; en = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            drive(c, 0);
            step();
            chk("ab_valid", win_valid, (c >= 2) ? 1 : 0);
        end
        chk("ab_w3", win, ew(4, 0));
        drive(5, 0);
        en = 1'b0;
        step();
        chk_zero("ab_out");
        in_valid = 1'b0; en = 1'b1;
        step();
        chk("ab_restart_busy", busy, 1);
        for (int c = 0; c < 3; c++) begin
            drive(c, 1);
            step();
            chk("ab_re_valid", win_valid, (c == 2) ? 1 : 0);
        end
        chk("ab_re_win", win, ew(2, 1));
        chk("ab_re_col", win_col, 0);
        chk("ab_re_row", win_row, 0);
        en = 1'b0; in_valid = 1'b0;
        step();

        // Asynchronous reset mid-RUN
        col = 9'd5; row = 9'd4; en = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            drive(c, 0);
            step();
        end
        chk("rst_pre_valid", win_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        en = 1'b0; in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rst_idle_busy", busy, 0);
        en = 1'b1;
        step();
        chk("rst_run_busy", busy, 1);
        for (int c = 0; c < 3; c++) begin
            drive(c, 1);
            step();
        end
        chk("rst_re_valid", win_valid, 1);
        chk("rst_re_win", win, ew(2, 1));
        chk("rst_re_col", win_col, 0);
        chk("rst_re_row", win_row, 0);
        en = 1'b0; in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
